sr_session_scheduler: RTL

- Hardware session sequencer for phi_n_neural_processor. It replaces bench-driven phase control by stepping the processor through WARMUP, NORMAL, MEDITATION and SR_DRIVE phases.
- Drives state_select, sensory_input and sr_field_packed, ramps the Schumann drive amplitude, and emits decimated sample strobes with phase tags for the telemetry capture path.
- Advances only on the 4 kHz clock-enable.

---
 rtl/sr_session_pkg.sv | 46 ++++
 rtl/sr_drive_ramp.sv | 59 +++++
 rtl/sr_session_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sr_session_pkg.sv
// Shared encodings and default constants for the SR session scheduler.
//   state_e      : FSM state encoding
//   TAG_*        : phase_tag codes carried with each sample strobe
//   SEL_*        : state_select codes understood by phi_n_neural_processor
//   DEF_*        : default word width, sensory levels and ramp constants
package sr_session_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WARMUP     = 3'd1,
        ST_NORMAL     = 3'd2,
        ST_MEDITATION = 3'd3,
        ST_SR_DRIVE   = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    localparam logic [1:0] TAG_WARMUP     = 2'd0;
    localparam logic [1:0] TAG_NORMAL     = 2'd1;
    localparam logic [1:0] TAG_MEDITATION = 2'd2;
    localparam logic [1:0] TAG_SR_DRIVE   = 2'd3;

    localparam logic [2:0] SEL_NORMAL     = 3'd0;
    localparam logic [2:0] SEL_MEDITATION = 3'd1;

    localparam int unsigned COUNT_W       = 16;
    localparam int unsigned DEF_WIDTH     = 18;
    localparam int unsigned DEF_SENS_NORM = 4096;
    localparam int unsigned DEF_SENS_MED  = 1024;
    localparam int unsigned DEF_SENS_SR   = 512;
    localparam int unsigned DEF_SR_AMP    = 12288;
    localparam int unsigned DEF_RAMP_STEP = 256;

    // Phase tag reported for a strobe issued while in the given busy state.
    function automatic logic [1:0] state_tag(input state_e s);
        logic [1:0] tag;
        tag = TAG_WARMUP;
        case (s)
            ST_NORMAL:     tag = TAG_NORMAL;
            ST_MEDITATION: tag = TAG_MEDITATION;
            ST_SR_DRIVE:   tag = TAG_SR_DRIVE;
            default:       tag = TAG_WARMUP;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/sr_drive_ramp.sv
// Saturating Schumann drive amplitude ramp with per-harmonic mask fan-out.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force amplitude to 0 (takes priority over step)
//   step     : add RAMP_STEP, saturating at SR_AMP
//   mask     : per-harmonic enable
//   field    : registered packed field, harmonic h at [h*WIDTH +: WIDTH]
module sr_drive_ramp
    import sr_session_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned NUM_HARMONICS = 5,
    parameter int unsigned SR_AMP        = DEF_SR_AMP,
    parameter int unsigned RAMP_STEP     = DEF_RAMP_STEP
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clear,
    input  logic                                    step,
    input  logic [NUM_HARMONICS-1:0]                mask,
    output logic signed [NUM_HARMONICS*WIDTH-1:0]   field
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0]               amp_q;
    logic [WIDTH-1:0]               amp_d;
    logic [SUM_W-1:0]               sum;
    logic [NUM_HARMONICS*WIDTH-1:0] field_d;

    // One extra bit of headroom so the add cannot wrap before the clamp.
    always_comb begin
        sum   = {1'b0, amp_q} + SUM_W'(RAMP_STEP);
        amp_d = amp_q;
        if (clear) begin
            amp_d = '0;
        end else if (step) begin
            amp_d = (sum > SUM_W'(SR_AMP)) ? WIDTH'(SR_AMP) : sum[WIDTH-1:0];
        end
    end

    // Field follows the next amplitude so it changes on the same edge as amp.
    always_comb begin
        field_d = '0;
        for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
            field_d[h*WIDTH +: WIDTH] = mask[h] ? amp_d : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_q <= '0;
            field <= '0;
        end else begin
            amp_q <= amp_d;
            field <= field_d;
        end
    end

endmodule

// File: rtl/sr_session_scheduler.sv
// Session sequencer for phi_n_neural_processor: steps WARMUP -> NORMAL ->
// MEDITATION -> SR_DRIVE -> DONE on the 4 kHz clk_en, decimating to sample strobes.
//   clk, rst, clk_en         : clock, async active-high reset, 4 kHz enable
//   start, abort             : session control (abort has priority)
//   harmonic_enable          : SR harmonic mask, captured on accepted start
//   state_select             : processor state code
//   sensory_input            : sensory drive level
//   sr_field_packed          : per-harmonic SR field
//   sample_strobe, phase_tag : decimated capture pulse and its phase
//   sample_count             : strobes issued this session
//   busy, done               : session status
module sr_session_scheduler
    import sr_session_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned NUM_HARMONICS = 5,
    parameter int unsigned DECIM         = 10,
    parameter int unsigned WARM_LEN      = 1000,
    parameter int unsigned NORM_LEN      = 2000,
    parameter int unsigned MED_LEN       = 2000,
    parameter int unsigned SR_LEN        = 3000,
    parameter int unsigned SENS_NORM     = DEF_SENS_NORM,
    parameter int unsigned SENS_MED      = DEF_SENS_MED,
    parameter int unsigned SENS_SR       = DEF_SENS_SR,
    parameter int unsigned SR_AMP        = DEF_SR_AMP,
    parameter int unsigned RAMP_STEP     = DEF_RAMP_STEP
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_en,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [NUM_HARMONICS-1:0]               harmonic_enable,
    output logic [2:0]                             state_select,
    output logic signed [WIDTH-1:0]                sensory_input,
    output logic signed [NUM_HARMONICS*WIDTH-1:0]  sr_field_packed,
    output logic                                   sample_strobe,
    output logic [1:0]                             phase_tag,
    output logic [COUNT_W-1:0]                     sample_count,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned TICK_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned END_WARM = WARM_LEN;
    localparam int unsigned END_NORM = END_WARM + NORM_LEN;
    localparam int unsigned END_MED  = END_NORM + MED_LEN;
    localparam int unsigned END_SR   = END_MED + SR_LEN;

    if (END_SR > 65535) begin : g_len_check
        $error("sr_session_scheduler: total session length exceeds sample_count range");
    end

    state_e                    state_q, state_d;
    logic [TICK_W-1:0]         tick_q, tick_d;
    logic [COUNT_W-1:0]        count_d;
    logic [1:0]                tag_d;
    logic [NUM_HARMONICS-1:0]  mask_q, mask_d;
    logic                      strobe_d;
    logic [2:0]                sel_d;
    logic [WIDTH-1:0]          sens_d;
    logic                      busy_d, done_d;
    logic                      in_busy;
    logic                      ramp_step_c, ramp_clear_c;
    int unsigned               phase_end;
    state_e                    next_phase;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        count_d      = sample_count;
        tag_d        = phase_tag;
        mask_d       = mask_q;
        strobe_d     = 1'b0;
        ramp_step_c  = 1'b0;
        phase_end    = END_SR;
        next_phase   = ST_DONE;
        sel_d        = SEL_NORMAL;
        sens_d       = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        in_busy      = (state_q == ST_WARMUP) || (state_q == ST_NORMAL) ||
                       (state_q == ST_MEDITATION) || (state_q == ST_SR_DRIVE);

        case (state_q)
            ST_WARMUP:     begin phase_end = END_WARM; next_phase = ST_NORMAL;     end
            ST_NORMAL:     begin phase_end = END_NORM; next_phase = ST_MEDITATION; end
            ST_MEDITATION: begin phase_end = END_MED;  next_phase = ST_SR_DRIVE;   end
            default:       begin phase_end = END_SR;   next_phase = ST_DONE;       end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            count_d = '0;
            tag_d   = TAG_WARMUP;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            state_d = ST_WARMUP;
            tick_d  = '0;
            count_d = '0;
            tag_d   = TAG_WARMUP;
            mask_d  = harmonic_enable;
        end else if (in_busy && clk_en) begin
            ramp_step_c = (state_q == ST_SR_DRIVE);
            if (tick_q == TICK_W'(DECIM - 1)) begin
                tick_d   = '0;
                strobe_d = 1'b1;
                tag_d    = state_tag(state_q);
                count_d  = sample_count + COUNT_W'(1);
                // Strobe that closes a phase is still tagged with that phase.
                if (count_d == COUNT_W'(phase_end)) begin
                    state_d = next_phase;
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_d)
            ST_WARMUP, ST_NORMAL: begin
                sens_d = WIDTH'(SENS_NORM);
                busy_d = 1'b1;
            end
            ST_MEDITATION: begin
                sel_d  = SEL_MEDITATION;
                sens_d = WIDTH'(SENS_MED);
                busy_d = 1'b1;
            end
            ST_SR_DRIVE: begin
                sel_d  = SEL_MEDITATION;
                sens_d = WIDTH'(SENS_SR);
                busy_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Amplitude only lives while the FSM stays in SR_DRIVE.
    assign ramp_clear_c = (state_d != ST_SR_DRIVE);

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            mask_q        <= '0;
            sample_count  <= '0;
            phase_tag     <= '0;
            sample_strobe <= 1'b0;
            state_select  <= '0;
            sensory_input <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            mask_q        <= mask_d;
            sample_count  <= count_d;
            phase_tag     <= tag_d;
            sample_strobe <= strobe_d;
            state_select  <= sel_d;
            sensory_input <= sens_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    sr_drive_ramp #(
        .WIDTH         (WIDTH),
        .NUM_HARMONICS (NUM_HARMONICS),
        .SR_AMP        (SR_AMP),
        .RAMP_STEP     (RAMP_STEP)
    ) u_ramp (
        .clk   (clk),
        .rst   (rst),
        .clear (ramp_clear_c),
        .step  (ramp_step_c),
        .mask  (mask_d),
        .field (sr_field_packed)
    );

endmodule
